// File: rtl/alu_result_collector_if.sv
// Producer/consumer bundle of the ALU result collector.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid && ready;
// the collector is the slave of both the in_* and the out_* signals.
interface alu_result_collector_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [31:0] in_conclusion;
    logic        in_balancebit;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_result;
    logic [5:0]  out_opcode;
    logic        out_err;

    modport slave (
        input  in_valid, in_opcode, in_conclusion, in_balancebit, out_ready,
        output in_ready, out_valid, out_result, out_opcode, out_err
    );

    modport master (
        output in_valid, in_opcode, in_conclusion, in_balancebit, out_ready,
        input  in_ready, out_valid, out_result, out_opcode, out_err
    );
endinterface

// File: rtl/alu_result_collector.sv
// Integrity-checks ALU results (parity + sign extension), tags them and buffers them in a FIFO.
// Optional saturating error counter enabled by defining RESULT_ERR_COUNT_EN.
module alu_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_collector_if.slave bus,
    output logic                 overflow,
    output logic [CNT_W-1:0]     err_count,
    output logic [1:0]           fill_state
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] OCC_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_e;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          par_ok;
    logic          sext_ok;
    logic          err;
    logic [11:0]   head;
    fill_e         fill;

    always_comb begin
        par_ok  = (bus.in_balancebit == ~^bus.in_conclusion[4:0]);
        sext_ok = (bus.in_conclusion[31:5] == {27{bus.in_conclusion[4]}});
        err     = !(par_ok && sext_ok);
        full    = (occ == DEPTH_C);
        empty   = (occ == '0);
        // in_ready comes from registered occupancy, so a pop never frees a slot in the same cycle.
        push    = bus.in_valid && !full;
        pop     = !empty && bus.out_ready;
    end

    always_comb begin
        fill = FILL_PARTIAL;
        if (empty)
            fill = FILL_EMPTY;
        else if (full)
            fill = FILL_FULL;
    end

    assign fill_state = fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {bus.in_opcode, bus.in_conclusion[4:0], err};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
            if (bus.in_valid && full)
                overflow <= 1'b1;
        end
    end

`ifdef RESULT_ERR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (push && err && (err_count != '1))
            err_count <= err_count + CNT_W'(1);
    end
`else
    assign err_count = '0;
`endif

    assign head          = mem[rd_ptr];
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_opcode = head[11:6];
    assign bus.out_result = head[5:1];
    assign bus.out_err    = head[0];
endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Downstream stage of the ALU arithmetic units (subtraction, addition, ...). Accepts each unit's 32-bit sign-extended result, its parity bit and the 6-bit opcode. Checks the result's integrity, tags it with an error flag and buffers it in a small FIFO. The FIFO drains to the display/printout logic over a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer presents a result this cycle
in_ready  output  1  collector can accept; equals !full
in_opcode  input  6  opcode that produced the result (6'b000010 = subtract)
in_conclusion  input  32  sign-extended result from the ALU unit
in_balancebit  input  1  producer parity bit: 1 = even number of ones in in_conclusion[4:0]
out_valid  output  1  FIFO head is valid
out_ready  input  1  consumer takes the head this cycle
out_result  output  5  head result, low 5 bits
out_opcode  output  6  head opcode
out_err  output  1  head failed the integrity check
overflow  output  1  sticky: a write was attempted while full
err_count  output  CNT_W  number of accepted results that failed the check

Behaviour:
- Reset (async, active-high), all state cleared:
  - read and write pointers = 0; occupancy = 0
  - out_valid = 0, out_result = 0, out_opcode = 0, out_err = 0
  - overflow = 0, err_count = 0
  - in_ready = 1 immediately after reset deasserts
- Reset asserted mid-operation discards all buffered entries. No partial pop or push completes on that edge.
- Push occurs when in_valid && in_ready on a rising clk edge.
- Integrity check, evaluated combinationally on the inputs at push:
  - par_ok = (in_balancebit == ~^in_conclusion[4:0])
  - sext_ok = (in_conclusion[31:5] all equal in_conclusion[4])
  - err = !(par_ok && sext_ok)
- Stored entry = {in_opcode, in_conclusion[4:0], err}.
- Pop occurs when out_valid && out_ready on a rising edge; the read pointer advances.
- out_* outputs are driven from the storage entry at the read pointer. out_valid = (occupancy != 0).
- Latency: a push at edge N makes the entry visible with out_valid=1 after edge N (1 cycle) when the FIFO was empty. There is no fall-through in the same cycle.
- Occupancy counter, width log2(DEPTH)+1; pointers wrap modulo DEPTH:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance
- Full (occupancy == DEPTH):
  - in_ready = 0
  - in_valid=1 sets overflow=1 (sticky until reset); the data is dropped
  - a simultaneous pop does not enable a push in that cycle, because in_ready is registered-state derived
- Empty: out_ready is ignored; no pointer change.
- out_result and out_opcode hold stable while out_valid=1 && out_ready=0.
- No state machine beyond the FIFO occupancy states (EMPTY / PARTIAL / FULL), which follow directly from the occupancy count.

Optional Feature:
RESULT_ERR_COUNT_EN
- Defined: err_count increments by 1 on every push with err=1, saturating at 2^CNT_W-1. It is cleared only by reset.
- Undefined: the counter logic is not built and err_count is tied to 0. out_err per entry is still produced.

Test Plan:
1. Reset, then push opcode 000010, conclusion 32'hFFFF_FFFD (tempp=11101, four ones), balancebit=1 -> next cycle out_valid=1, out_result=5'b11101, out_opcode=6'b000010, out_err=0.
2. Push conclusion 32'h0000_0003 with balancebit=0 (two ones, so 1 expected) -> out_err=1; with RESULT_ERR_COUNT_EN defined, err_count=1, otherwise 0.
3. Push conclusion 32'h0001_0010 with correct parity 0 (one one) -> out_err=1 from the sign-extension mismatch.
4. DEPTH=4, out_ready=0, five consecutive pushes -> in_ready=0 after the 4th push; 5th attempt sets overflow=1. Drain yields exactly the first 4 entries in order, and overflow stays 1.
5. Occupancy 2, in_valid=1 and out_ready=1 held for 6 cycles -> occupancy stays 2, pointers wrap past DEPTH-1, output order is preserved.
6. Fill with 3 entries, assert reset between edges -> out_valid=0, in_ready=1, err_count=0 asynchronously; the first push after reset appears as the sole entry.
